// File: rtl/dmem_responder_if.sv
// Core-to-DMEM load/store interface.
//   master : core side, drives the request and receives the response
//   slave  : responder side (dmem_responder)
// Request : req_valid/req_ready handshake, plus req_we, req_funct3, req_addr and req_wdata
// Response: resp_valid (one-cycle pulse), resp_rdata, resp_err
interface dmem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target on the core's load/store port.
// It accepts one RV32I load or store (funct3 B/H/W/BU/HU) through a valid/ready
// handshake. It then waits WAIT_CYCLES states and returns a one-cycle response
// with the load data and an error flag. The RAM holds 2**(ADDR_W-2) words and is
// split into four byte lanes.
// Ports:
//   CLK   clock, rising edge
//   RSTn  asynchronous active-low reset (the RAM contents are not cleared)
//   bus   dmem_responder_if.slave, carrying the request and response signals
// Build option: when DMEM_MISALIGN_ERR_EN is defined, a misaligned H/W access
// is rejected with resp_err. Otherwise the low address bits are forced to
// natural alignment.

// One byte lane of the RAM: asynchronous read, synchronous write, no reset.
module dmem_lane #(
  parameter int IDX_W = 8
) (
  input  logic             CLK,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata
);
  logic [7:0] r_mem [0:(2**IDX_W)-1];

  always_ff @(posedge CLK)
    if (i_we) r_mem[i_idx] <= i_wdata;

  assign o_rdata = r_mem[i_idx];
endmodule

module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            CLK,
  input  logic            RSTn,
  dmem_responder_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = ADDR_W - 2;
  localparam logic [3:0] CNT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic              we;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t r_state, w_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  req_t        r_req, w_req;
  logic        w_commit;
  logic [31:0] r_rdata;
  logic        r_err;

  // In IDLE, decode straight from the bus, so that a zero-wait request can
  // commit on its accept edge. Later states use the captured copy.
  assign w_req = (r_state == S_IDLE) ?
                 '{we: bus.req_we, f3: bus.req_funct3, addr: bus.req_addr, wdata: bus.req_wdata} :
                 r_req;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        if (WAIT_CYCLES > 0) begin
          w_nxt     = S_WAIT;
          w_cnt_nxt = CNT_LD;
        end else begin
          w_nxt    = S_RESP;
          w_commit = 1'b1;
        end
      end
      S_WAIT: if (r_cnt == 4'd0) begin
        w_nxt    = S_RESP;
        w_commit = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Access decode. Size comes from funct3[1:0]; funct3[2] selects zero-extension.
  logic [1:0] w_size, w_a;
  logic       w_f3_bad, w_mis, w_err;
  assign w_size = w_req.f3[1:0];
  // A store must have funct3[2]=0. A load rejects size 11 and the unsigned word form (110).
  assign w_f3_bad = w_req.we ? (w_req.f3[2] || (w_size == 2'b11))
                             : ((w_size == 2'b11) || (w_req.f3[2] && (w_size == 2'b10)));
`ifdef DMEM_MISALIGN_ERR_EN
  assign w_mis = ((w_size == 2'b01) && w_req.addr[0]) ||
                 ((w_size == 2'b10) && (w_req.addr[1:0] != 2'b00));
  assign w_a   = w_req.addr[1:0];
`else
  assign w_mis = 1'b0;
  assign w_a   = (w_size == 2'b10) ? 2'b00 :
                 (w_size == 2'b01) ? {w_req.addr[1], 1'b0} : w_req.addr[1:0];
`endif
  assign w_err = w_f3_bad || w_mis;

  // Replicate the store data across the word, so each enabled lane picks up the right byte.
  logic [NUM_LANES-1:0]       w_be;
  logic [31:0]                w_wword;
  logic [NUM_LANES-1:0][7:0]  w_rword;
  logic [31:0]                w_sh, w_ld;
  always_comb begin
    case (w_size)
      2'b00:   begin w_be = 4'b0001 << w_a; w_wword = {4{w_req.wdata[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << w_a; w_wword = {2{w_req.wdata[15:0]}}; end
      default: begin w_be = 4'b1111;        w_wword = w_req.wdata;            end
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_lane #(.IDX_W(IDX_W)) u_lane (
      .CLK     (CLK),
      .i_we    (w_commit && w_req.we && !w_err && w_be[g]),
      .i_idx   (w_req.addr[ADDR_W-1:2]),
      .i_wdata (w_wword[g*8 +: 8]),
      .o_rdata (w_rword[g])
    );
  end

  assign w_sh = w_rword >> {w_a, 3'b000};
  always_comb begin
    case (w_size)
      2'b00:   w_ld = w_req.f3[2] ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ld = w_req.f3[2] ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_rword;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && bus.req_valid) r_req <= w_req;
      if (w_commit) begin
        r_rdata <= (w_req.we || w_err) ? 32'd0 : w_ld;
        r_err   <= w_err;
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule
